hub75_bcm_show: RTL
===================

# hub75_bcm_show

Display-phase stage of the HUB75 screen controller, directly downstream of the latch synchroniser. Each one-cycle synced-latch pulse triggers one display window. The block drives the panel row address, then unblanks the panel (OE low) for a binary-weighted time set by the current bit plane. It owns the plane/row scan counters that tell the upstream shift stage what to load next, and it pulses done when the panel is blanked again.

## Interface
- PLANES, 8, number of bit planes (BCM depth); valid 1–8
- ROW_BITS, 5, width of the panel row address (32 scan rows)
- BASE_TICKS, 16, ON time in clk cycles for plane 0; must be ≥1
- GUARD, 2, blanked cycles before and after each ON window; must be ≥1
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_synced_hub75_latch  in  1  one-cycle show-request pulse from the latch synchroniser
- out_hub75_oe_n  out  1  panel output enable, active low (1 = blanked)
- out_hub75_addr  out  ROW_BITS  row address driven to the panel
- out_cur_plane  out  clog2(PLANES) (min 1)  plane the upstream stage must shift next
- out_cur_row  out  ROW_BITS  row the upstream stage must shift next
- out_busy  out  1  high while a show window is in progress
- out_show_done  out  1  one-cycle pulse: window finished, counters advanced
- out_overrun  out  1  one-cycle pulse: show request arrived while busy and was dropped

## Operation
- FSM states: IDLE, PRE, ON, POST, DONE. A single down-counter times PRE, ON and POST.
- IDLE: OE_n=1, busy=0. A request pulse moves the FSM to PRE and performs these loads:
  - out_hub75_addr ← out_cur_row;
  - the displayed plane p is captured into an internal register;
  - the counter is loaded with GUARD−1.
- PRE: OE_n=1. When counter=0, go to ON and load counter with (BASE_TICKS<<p)−1.
- ON: OE_n=0. When counter=0, go to POST and load counter with GUARD−1.
- POST: OE_n=1. When counter=0, go to DONE.
- DONE: OE_n=1, show_done=1 for this cycle, next state IDLE. Counters advance:
  - if out_cur_plane = PLANES−1, then out_cur_plane ← 0 and out_cur_row ← out_cur_row+1, wrapping modulo 2^ROW_BITS;
  - otherwise out_cur_plane ← out_cur_plane+1.
- A request in any state other than IDLE, including DONE, is ignored. out_overrun pulses on the next cycle. No queuing.
- Counter width: clog2(BASE_TICKS<<(PLANES−1)) + 1 bits. The shift must not truncate.
- out_hub75_addr changes only on the IDLE→PRE edge, so it never changes while OE_n=0.
- All outputs are registered.

## Timing
- Reset values: OE_n=1, addr=0, cur_plane=0, cur_row=0, busy=0, show_done=0, overrun=0, state IDLE. Reset mid-window aborts immediately: the panel is blanked on the next edge and the counters are not advanced.
- Request sampled high at edge T:
  - PRE occupies cycles T+1 … T+GUARD;
  - OE_n=0 for exactly BASE_TICKS<<p cycles;
  - POST lasts GUARD cycles;
  - show_done is high one cycle later.
- busy is high from T+1 through the DONE cycle inclusive. busy length = 2·GUARD + (BASE_TICKS<<p) + 1.
- out_cur_plane/out_cur_row hold the new value from the cycle after DONE.
- A request accepted in IDLE the cycle right after DONE starts a new window with no gap. Maximum request rate is one per busy+1 cycles.

## Structure
- Shared package hub75_pkg holds:
  - FSM state encoding (IDLE/PRE/ON/POST/DONE);
  - default PLANES, ROW_BITS, BASE_TICKS, GUARD;
  - the clog2-derived width localparams, reused by the upstream shift stage.
- One natural sub-module: hub75_scan_counter, the plane/row counter with wrap and advance enable. The FSM and timer stay in the top.

## Test plan
- Reset then idle, no request: OE_n=1, addr=0, plane=0, row=0, busy=0 held for 100 cycles.
- Defaults, single pulse at plane 0: OE_n low for exactly 16 cycles, starting 3 cycles after the pulse edge. show_done pulses 2 cycles after OE_n returns high. plane becomes 1.
- Eight back-to-back requests, each issued the cycle after show_done: ON widths 16, 32, …, 2048. After the 8th, plane=0, row=1, and addr=0 during all eight windows.
- Row wrap: drive 32×8 windows. Row goes 31→0. addr=31 during windows 249–256, then 0.
- Request pulse during ON, and one during DONE: each is dropped and overrun pulses once. Window timing and counters are unaffected.
- rst asserted mid-ON at plane 3, row 5: OE_n=1 next cycle, all outputs return to reset values, no show_done.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 display pipeline.
// Holds the show FSM encoding, default geometry and derived widths.
package hub75_pkg;

  localparam int PLANES_DEF     = 8;
  localparam int ROW_BITS_DEF   = 5;
  localparam int BASE_TICKS_DEF = 16;
  localparam int GUARD_DEF      = 2;

  function automatic int plane_w(input int planes);
    return (planes > 1) ? $clog2(planes) : 1;
  endfunction

  // one spare bit so the widest plane's ON time never truncates
  function automatic int cnt_w(input int base, input int planes);
    return $clog2(base << (planes - 1)) + 1;
  endfunction

  localparam int PLANE_W_DEF = plane_w(PLANES_DEF);
  localparam int CNT_W_DEF   = cnt_w(BASE_TICKS_DEF, PLANES_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ON,
    ST_POST,
    ST_DONE
  } show_st_t;

endpackage

// File: rtl/hub75_scan_counter.sv
// Plane/row scan position for the HUB75 show stage.
// Plane advances first; the row steps when the last plane wraps.
module hub75_scan_counter
  import hub75_pkg::*;
#(
  parameter int PLANES   = PLANES_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int PW       = plane_w(PLANES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adv_i,
  output logic [PW-1:0]       plane_o,
  output logic [ROW_BITS-1:0] row_o
);

  localparam logic [PW-1:0] LAST = PW'(PLANES - 1);

  logic [PW-1:0]       plane_q;
  logic [ROW_BITS-1:0] row_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      plane_q <= '0;
      row_q   <= '0;
    end else if (adv_i) begin
      if (plane_q == LAST) begin
        plane_q <= '0;
        row_q   <= row_q + 1'b1;
      end else begin
        plane_q <= plane_q + 1'b1;
      end
    end
  end

  assign plane_o = plane_q;
  assign row_o   = row_q;

endmodule

// File: rtl/hub75_bcm_show.sv
// HUB75 display-phase stage: addresses a row, then unblanks the
// panel for a binary-weighted time set by the current bit plane.
module hub75_bcm_show
  import hub75_pkg::*;
#(
  parameter int PLANES     = PLANES_DEF,
  parameter int ROW_BITS   = ROW_BITS_DEF,
  parameter int BASE_TICKS = BASE_TICKS_DEF,
  parameter int GUARD      = GUARD_DEF,
  parameter int PW         = plane_w(PLANES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_synced_hub75_latch,
  output logic                out_hub75_oe_n,
  output logic [ROW_BITS-1:0] out_hub75_addr,
  output logic [PW-1:0]       out_cur_plane,
  output logic [ROW_BITS-1:0] out_cur_row,
  output logic                out_busy,
  output logic                out_show_done,
  output logic                out_overrun
);

  localparam int CW = cnt_w(BASE_TICKS, PLANES);
  localparam logic [CW-1:0] GUARD_LD = CW'(GUARD - 1);

  show_st_t            state_q;
  logic [CW-1:0]       cnt_q;
  logic [PW-1:0]       plane_q;
  logic [ROW_BITS-1:0] addr_q;
  logic                oe_n_q;
  logic                busy_q;
  logic                done_q;
  logic                ovr_q;

  logic [CW-1:0]       on_ld_d;
  logic                cnt_zero;

  assign on_ld_d  = (CW'(BASE_TICKS) << plane_q) - CW'(1);
  assign cnt_zero = (cnt_q == '0);

  hub75_scan_counter #(
    .PLANES   (PLANES),
    .ROW_BITS (ROW_BITS),
    .PW       (PW)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (state_q == ST_DONE),
    .plane_o (out_cur_plane),
    .row_o   (out_cur_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      plane_q <= '0;
      addr_q  <= '0;
      oe_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovr_q  <= in_synced_hub75_latch
                && (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          if (in_synced_hub75_latch) begin
            state_q <= ST_PRE;
            addr_q  <= out_cur_row;
            plane_q <= out_cur_plane;
            cnt_q   <= GUARD_LD;
            busy_q  <= 1'b1;
          end
        end
        ST_PRE: begin
          if (cnt_zero) begin
            state_q <= ST_ON;
            cnt_q   <= on_ld_d;
            oe_n_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ON: begin
          if (cnt_zero) begin
            state_q <= ST_POST;
            cnt_q   <= GUARD_LD;
            oe_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_POST: begin
          if (cnt_zero) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          oe_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_hub75_oe_n = oe_n_q;
  assign out_hub75_addr = addr_q;
  assign out_busy       = busy_q;
  assign out_show_done  = done_q;
  assign out_overrun    = ovr_q;

endmodule
